nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder that streams operands one nibble per cycle through the
//  existing 4-bit ripple adder, fullAdder_4bits, with a registered carry between nibbles.
//  Sits directly upstream of fullAdder_4bits as its sequencer: drives its a/b/c_in and consumes its sum/c_out.
//  Gives wide additions with one 4-bit adder instance; start/busy/done control interface.
// PARAMETERS
//  WIDTH    16   operand/result width in bits; must be a multiple of 4 and >= 4
//  NIBBLES  WIDTH/4  derived localparam, number of ADD cycles
// PORTS
//  clk      in   1      rising-edge clock, single clock domain
//  rst_n    in   1      asynchronous reset, active-low
//  start    in   1      request; sampled only when busy==0
//  a        in   WIDTH  operand A, captured on accepted start
//  b        in   WIDTH  operand B, captured on accepted start
//  c_in     in   1      carry-in, captured on accepted start
//  busy     out  1      1 while in ADD state
//  done     out  1      single-cycle pulse: sum/c_out just updated
//  sum      out  WIDTH  result of last completed add, held until the next completion
//  c_out    out  1      carry-out of last completed add, held likewise
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; busy=0, done=0, sum=0, c_out=0; internal regs cleared.
//  - States: IDLE, ADD, DONE. FSM encoding is local to this file.
//  - IDLE/DONE: start=1 -> latch a,b into a_reg,b_reg; carry_reg<=c_in; idx<=0; acc<=0; go ADD.
//    Otherwise IDLE stays IDLE; DONE returns to IDLE.
//  - ADD, each cycle: adder inputs a_reg[4*idx+:4], b_reg[4*idx+:4], carry_reg.
//    acc[4*idx+:4]<=adder sum; carry_reg<=adder c_out; idx<=idx+1.
//    When idx==NIBBLES-1: sum<=final acc (incl. this nibble); c_out<=adder c_out; go DONE.
//  - DONE: done=1 for exactly this cycle; busy=0.
//  - Latency: start accepted at edge 0 -> done high in cycle NIBBLES+1 (5 for WIDTH=16).
//    Throughput: one add per NIBBLES+1 cycles; start held high in DONE restarts immediately.
//  - sum/c_out never show partial results; they change only on the edge entering DONE.
//  - start while busy=1 is ignored; input changes during ADD have no effect (operands latched).
//  - Arithmetic: {c_out,sum} == a + b + c_in exactly, modulo 2^(WIDTH+1); unsigned.
//  - Carry ripple across nibble boundaries is registered, never combinational across cycles.
//  - rst_n asserted mid-ADD: abort immediately, all outputs to reset values; no done pulse.
//  - WIDTH==4: single ADD cycle, done in cycle 2.
//  - idx width = max(1, $clog2(NIBBLES)); idx wrap is not used (exit on NIBBLES-1).
// STRUCTURE
//  - No shared package required; NIBBLES and idx width are localparams in this file.
//  - One sub-module: instance of existing fullAdder_4bits (sum, c_out, a, b, c_in), unmodified.
//  - Remainder: FSM, idx counter, a_reg/b_reg/acc/carry_reg, result registers.
// TESTING
//  - Reset: rst_n=0 at t0 -> busy=0, done=0, sum=0x0000, c_out=0 before first clk edge.
//  - a=0x0003,b=0x0004,c_in=0 pulse start -> done in cycle 5, sum=0x0007, c_out=0.
//  - a=0x1234,b=0x5678,c_in=1 -> sum=0x68AD, c_out=0; sum unchanged during cycles 1-4.
//  - a=0xFFFF,b=0x0001,c_in=0 -> sum=0x0000, c_out=1 (carry through all 4 nibbles).
//  - start pulsed at cycle 2 of an add with new operands -> ignored; first result intact;
//    start held in DONE cycle -> second add accepted, its done 5 cycles later.
//  - rst_n low for 1 cycle during ADD -> busy=0, sum=0, no done; next start a=0x00FF,
//    b=0x0001 -> sum=0x0100.
//  - WIDTH=4 build: a=0xA,b=0xF,c_in=1 -> done in cycle 2, sum=0xA, c_out=1.

Source files
------------

// File: rtl/fullAdder_4bits.sv
// fullAdder_4bits
//   Existing 4-bit ripple-carry adder. It is reproduced here only so the
//   slice elaborates on its own. The module name and port list are fixed by
//   its existing users and are kept exactly as they are.
//   Ports:
//     sum   out 4  a + b + c_in, low 4 bits
//     c_out out 1  carry out of bit 3
//     a     in  4  operand A
//     b     in  4  operand B
//     c_in  in  1  carry into bit 0
module fullAdder_4bits (
  output logic [3:0] sum,
  output logic       c_out,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in
);

  logic [4:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    c_out = carry[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Performs a WIDTH-bit add by streaming the operands through a single
//   fullAdder_4bits, one nibble per cycle, least-significant nibble first.
//   The carry between nibbles is held in a register, so no carry path spans
//   more than one nibble in any cycle.
//   The sum and c_out outputs update only on the edge that enters DONE, and
//   they hold their value until the next completion.
//   Ports:
//     clk    in  1      rising-edge clock
//     rst_n  in  1      asynchronous active-low reset
//     start  in  1      request; accepted in IDLE or DONE, ignored while busy
//     a, b   in  WIDTH  operands, latched when start is accepted
//     c_in   in  1      carry-in, latched when start is accepted
//     busy   out 1      high while nibbles are being added (ADD state)
//     done   out 1      one-cycle pulse after sum/c_out take a new result
//     sum    out WIDTH  result of the last completed add
//     c_out  out 1      carry-out of the last completed add
//   Control handshake: start is a level. It is accepted on any rising edge
//   where busy==0 and start==1. The bench must wait for done before it reads
//   the result. A start seen while busy==1 is dropped and is not queued.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_reg_q, a_reg_d;
  logic [WIDTH-1:0] b_reg_q, b_reg_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;

  logic [3:0]       add_a, add_b, add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] acc_ins;  // acc with this cycle's nibble merged in

  assign add_a = a_reg_q[4*idx_q +: 4];
  assign add_b = b_reg_q[4*idx_q +: 4];

  fullAdder_4bits u_fa4 (
    .sum   (add_sum),
    .c_out (add_cout),
    .a     (add_a),
    .b     (add_b),
    .c_in  (carry_q)
  );

  always_comb begin
    state_d = state_q;
    a_reg_d = a_reg_q;
    b_reg_d = b_reg_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    acc_ins = acc_q;
    acc_ins[4*idx_q +: 4] = add_sum;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_reg_d = a;
          b_reg_d = b;
          carry_d = c_in;
          idx_d   = '0;
          acc_d   = '0;
          state_d = S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADD: begin
        acc_d   = acc_ins;
        carry_d = add_cout;
        idx_d   = idx_q + IDX_W'(1);
        // On the last nibble, publish the result. Use acc_ins and not acc_q,
        // because acc_q does not yet hold the top nibble.
        if (idx_q == LAST_IDX) begin
          sum_d   = acc_ins;
          c_out_d = add_cout;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_reg_q <= '0;
      b_reg_q <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_reg_q <= a_reg_d;
      b_reg_q <= b_reg_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign busy  = (state_q == S_ADD);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder. It builds two instances: a
// WIDTH=16 instance and a WIDTH=4 instance, both on one clock and one reset.
module tb_nibble_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        c_in = 1'b0;
  logic        busy, done, c_out;
  logic [15:0] sum;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        c_in4 = 1'b0;
  logic        busy4, done4, c_out4;
  logic [3:0]  sum4;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .c_in(c_in4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(c_out4)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];
  logic [16:0] exp_res;
  logic [15:0] held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    a = va; b = vb; c_in = vc; start = 1'b1;
    exp_q.push_back({1'b0, va} + {1'b0, vb} + {16'b0, vc});
  endtask

  // Runs one complete add from IDLE. It checks that sum holds its old value
  // while busy, that done rises on the NIBBLES-th edge after acceptance, and
  // that the result matches the expected queue.
  task automatic run_add(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc);
    logic [15:0] prev;
    prev = sum;
    drive(va, vb, vc);
    tick();                       // edge 0: accepted
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      chk({tag, "_hold"}, 32'(sum), 32'(prev));
    end
    tick();                       // edge 4: enters DONE
    exp_res = exp_q.pop_front();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'(exp_res[15:0]));
    chk({tag, "_cout"}, 32'(c_out), 32'(exp_res[16]));
    tick();
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'h0000);
    chk("rst_cout", 32'(c_out), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    run_add("t3p4", 16'h0003, 16'h0004, 1'b0);
    chk("t3p4_val", 32'(sum), 32'h0007);
    run_add("t1234", 16'h1234, 16'h5678, 1'b1);
    chk("t1234_val", 32'(sum), 32'h68AD);
    run_add("tffff", 16'hFFFF, 16'h0001, 1'b0);
    chk("tffff_val", 32'({c_out, sum}), 32'h10000);
    run_add("tmax", 16'hFFFF, 16'hFFFF, 1'b1);

    // A start while busy is ignored, and a start held in DONE restarts.
    drive(16'h0101, 16'h0202, 1'b0);
    tick();
    start = 1'b0;
    tick(); tick();               // cycle 2 of the add
    a = 16'hAAAA; b = 16'h5555; c_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();                       // enters DONE
    exp_res = exp_q.pop_front();
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_sum", 32'({c_out, sum}), 32'(exp_res));
    chk("ign_val", 32'(sum), 32'h0303);
    drive(16'h0F0F, 16'h00F1, 1'b1);  // start held during DONE
    tick();
    start = 1'b0;
    chk("rs_busy", 32'(busy), 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("rs_nodone", 32'(done), 32'd0);
    end
    tick();
    exp_res = exp_q.pop_front();
    chk("rs_done", 32'(done), 32'd1);
    chk("rs_sum", 32'({c_out, sum}), 32'(exp_res));
    chk("rs_val", 32'(sum), 32'h1001);
    tick();

    // Assert reset in the middle of ADD. The add is aborted and produces no
    // done pulse.
    drive(16'h1111, 16'h2222, 1'b0);
    tick();
    start = 1'b0;
    void'(exp_q.pop_front());     // this add is aborted
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_sum", 32'(sum), 32'h0000);
    chk("ab_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ab_nodone", 32'(done), 32'd0);
    end
    run_add("tpost", 16'h00FF, 16'h0001, 1'b0);
    chk("tpost_val", 32'(sum), 32'h0100);

    // WIDTH=4 instance: A + F + 1 = 0x1A.
    a4 = 4'hA; b4 = 4'hF; c_in4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("w4_busy", 32'(busy4), 32'd1);
    chk("w4_nodone", 32'(done4), 32'd0);
    tick();
    chk("w4_done", 32'(done4), 32'd1);
    chk("w4_sum", 32'(sum4), 32'hA);
    chk("w4_cout", 32'(c_out4), 32'd1);
    tick();
    chk("w4_pulse", 32'(done4), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
